// File: rtl/alu_regfile_blackbox.sv
// Behavioural core for a small RV64 sandbox: ALU, 32x64 register file, byte-masked
// data memory with a second fetch read port, and a sticky ebreak halt flag.
module alu_regfile_blackbox #(
  parameter logic [63:0] MEM_BASE  = 64'h0000_0000_8000_0000,
  parameter int          MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] alu_src1,
  input  logic [63:0] alu_src2,
  input  logic [1:0]  aluop,
  output logic [63:0] alu_result,
  input  logic [4:0]  rf_raddr1,
  input  logic [4:0]  rf_raddr2,
  output logic [63:0] rf_rdata1,
  output logic [63:0] rf_rdata2,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [63:0] rf_wdata,
  input  logic [63:0] mem_raddr,
  input  logic        mem_read,
  output logic [63:0] mem_rdata,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  input  logic        mem_write,
  input  logic        inst_ready,
  input  logic [63:0] pc,
  output logic [63:0] inst_2,
  input  logic        ebreak,
  output logic        halted
);

  localparam int          IDXW      = $clog2(MEM_DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'd8;

  logic [63:0]     r_regs [0:31];
  logic [63:0]     r_mem  [0:MEM_DEPTH-1];
  logic            r_halted;

  logic [63:0]     w_roff, w_woff, w_foff;
  logic            w_rinrange, w_winrange, w_finrange;
  logic [IDXW-1:0] w_ridx, w_widx, w_fidx;
  logic            w_memWe;

  always_comb begin
    alu_result = 64'd0;
    case (aluop)
      2'b01:   alu_result = alu_src1 + alu_src2;
      2'b10:   alu_result = {63'd0, alu_src1 < alu_src2};
      default: alu_result = 64'd0;
    endcase
  end

  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 64'd0 : r_regs[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 64'd0 : r_regs[rf_raddr2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 64'd0;
    end else if (rf_we && !r_halted && rf_waddr != 5'd0) begin
      r_regs[rf_waddr] <= rf_wdata;
    end
  end

  // Offsets below MEM_BASE wrap to huge values, so one unsigned compare covers both bounds.
  assign w_roff     = mem_raddr - MEM_BASE;
  assign w_woff     = mem_waddr - MEM_BASE;
  assign w_foff     = pc - MEM_BASE;
  assign w_rinrange = w_roff < MEM_BYTES;
  assign w_winrange = w_woff < MEM_BYTES;
  assign w_finrange = w_foff < MEM_BYTES;
  assign w_ridx     = w_roff[IDXW+2:3];
  assign w_widx     = w_woff[IDXW+2:3];
  assign w_fidx     = w_foff[IDXW+2:3];

  assign mem_rdata = (mem_read && w_rinrange) ? r_mem[w_ridx] : 64'd0;
  assign inst_2    = (inst_ready && w_finrange) ? r_mem[w_fidx] : 64'd0;

  assign w_memWe = mem_write && w_winrange && !r_halted && !rst;

  // Memory has no reset; rst only gates the write enable.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_wmask[b]) r_mem[w_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_halted <= 1'b0;
    else if (ebreak) r_halted <= 1'b1;
  end

  assign halted = r_halted;

endmodule

// File: tb/tb_alu_regfile_blackbox.sv
// Directed self-checking bench for alu_regfile_blackbox: ALU, regfile, masked memory,
// fetch port, halt and reset behaviour with hand-computed expectations.
module tb_alu_regfile_blackbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_src1, alu_src2;
  logic [1:0]  aluop;
  logic [63:0] alu_result;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [63:0] rf_rdata1, rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [63:0] mem_raddr;
  logic        mem_read;
  logic [63:0] mem_rdata;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_write;
  logic        inst_ready;
  logic [63:0] pc;
  logic [63:0] inst_2;
  logic        ebreak;
  logic        halted;

  int nCompared   = 0;
  int nMismatched = 0;

  alu_regfile_blackbox dut (
    .clk(clk), .rst(rst),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .aluop(aluop), .alu_result(alu_result),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_raddr(mem_raddr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_write(mem_write),
    .inst_ready(inst_ready), .pc(pc), .inst_2(inst_2),
    .ebreak(ebreak), .halted(halted)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge so nothing races the clock.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] mask);
    mem_waddr = addr;
    mem_wdata = data;
    mem_wmask = mask;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic readMem(input logic [63:0] addr);
    mem_raddr = addr;
    mem_read  = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_src1 = '0; alu_src2 = '0; aluop = 2'b00;
    rf_raddr1 = 5'd5; rf_raddr2 = 5'd0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    mem_raddr = '0; mem_read = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_wmask = '0; mem_write = 1'b0;
    inst_ready = 1'b0; pc = '0; ebreak = 1'b0;
    #2;
    checkOutput("reset_x5", rf_rdata1, 64'd0);
    checkOutput("reset_halted", {63'd0, halted}, 64'd0);
    tick();
    tick();
    rst = 1'b0;

    alu_src1 = 64'd5; alu_src2 = -64'sd3; aluop = 2'b01; #1;
    checkOutput("alu_add", alu_result, 64'd2);
    alu_src1 = 64'd1; alu_src2 = 64'hFFFF_FFFF_FFFF_FFFF; aluop = 2'b10; #1;
    checkOutput("alu_sltu_true", alu_result, 64'd1);
    aluop = 2'b00; #1;
    checkOutput("alu_op00", alu_result, 64'd0);
    aluop = 2'b11; #1;
    checkOutput("alu_op11", alu_result, 64'd0);
    alu_src1 = 64'hFFFF_FFFF_FFFF_FFFF; alu_src2 = 64'd1; aluop = 2'b10; #1;
    checkOutput("alu_sltu_false", alu_result, 64'd0);

    rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 64'hDEAD_BEEF; rf_raddr1 = 5'd5; #1;
    checkOutput("rf_same_cycle_old", rf_rdata1, 64'd0);
    tick();
    checkOutput("rf_x5", rf_rdata1, 64'hDEAD_BEEF);
    rf_waddr = 5'd0; rf_wdata = 64'd7; rf_raddr2 = 5'd0;
    tick();
    checkOutput("rf_x0", rf_rdata2, 64'd0);
    rf_waddr = 5'd31; rf_wdata = 64'hA5A5_0000_FFFF_1234; rf_raddr2 = 5'd31;
    tick();
    rf_we = 1'b0;
    checkOutput("rf_x31", rf_rdata2, 64'hA5A5_0000_FFFF_1234);
    checkOutput("rf_x5_kept", rf_rdata1, 64'hDEAD_BEEF);

    applyStimulus(64'h8000_1000, 64'h1234_5678_8765_4321, 8'hFF);
    readMem(64'h8000_1000);
    checkOutput("mem_full_write", mem_rdata, 64'h1234_5678_8765_4321);
    mem_waddr = 64'h8000_1000; mem_wdata = 64'h8765_4321_1234_5678; mem_wmask = 8'hAA; mem_write = 1'b1; #1;
    checkOutput("mem_pre_edge", mem_rdata, 64'h1234_5678_8765_4321);
    tick();
    mem_write = 1'b0;
    checkOutput("mem_masked", mem_rdata, 64'h8734_4378_1265_5621);
    mem_read = 1'b0; #1;
    checkOutput("mem_read_off", mem_rdata, 64'd0);

    applyStimulus(64'h8000_0000, 64'h0010_0073_0000_0013, 8'hFF);
    applyStimulus(64'h8000_1FF8, 64'h0BAD_F00D_CAFE_0001, 8'hFF);
    readMem(64'h8000_1FFF);
    checkOutput("mem_last_word", mem_rdata, 64'h0BAD_F00D_CAFE_0001);
    readMem(64'h8000_0005);
    checkOutput("mem_low_bits_ignored", mem_rdata, 64'h0010_0073_0000_0013);

    pc = 64'h8000_0004; inst_ready = 1'b1; #1;
    checkOutput("fetch_on", inst_2, 64'h0010_0073_0000_0013);
    inst_ready = 1'b0; #1;
    checkOutput("fetch_off", inst_2, 64'd0);
    pc = 64'h8000_2000; inst_ready = 1'b1; #1;
    checkOutput("fetch_oor", inst_2, 64'd0);
    inst_ready = 1'b0;

    applyStimulus(64'h7FFF_FFF8, 64'h1111_2222_3333_4444, 8'hFF);
    applyStimulus(64'h8000_2000, 64'h5555_6666_7777_8888, 8'hFF);
    readMem(64'h7FFF_FFF8);
    checkOutput("mem_oor_low_read", mem_rdata, 64'd0);
    readMem(64'h8000_2000);
    checkOutput("mem_oor_high_read", mem_rdata, 64'd0);
    readMem(64'h8000_1FF8);
    checkOutput("mem_oor_low_no_alias", mem_rdata, 64'h0BAD_F00D_CAFE_0001);
    readMem(64'h8000_0000);
    checkOutput("mem_oor_high_no_alias", mem_rdata, 64'h0010_0073_0000_0013);

    ebreak = 1'b1;
    tick();
    ebreak = 1'b0;
    checkOutput("halt_set", {63'd0, halted}, 64'd1);
    rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 64'd9; rf_raddr1 = 5'd3;
    tick();
    rf_we = 1'b0;
    checkOutput("halt_rf_blocked", rf_rdata1, 64'd0);
    applyStimulus(64'h8000_1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    readMem(64'h8000_1000);
    checkOutput("halt_mem_blocked", mem_rdata, 64'h8734_4378_1265_5621);
    checkOutput("halt_sticky", {63'd0, halted}, 64'd1);

    rf_raddr1 = 5'd5;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_halted_async", {63'd0, halted}, 64'd0);
    checkOutput("rst_regs_async", rf_rdata1, 64'd0);
    applyStimulus(64'h8000_1FF8, 64'h9999_9999_9999_9999, 8'hFF);
    readMem(64'h8000_1FF8);
    checkOutput("rst_mem_write_blocked", mem_rdata, 64'h0BAD_F00D_CAFE_0001);
    readMem(64'h8000_1000);
    checkOutput("rst_mem_retained", mem_rdata, 64'h8734_4378_1265_5621);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
